// File: rtl/frame_mem_arbiter_pkg.sv
// Shared definitions for the frame memory arbiter: requester IDs and default sizing.
package frame_mem_arbiter_pkg;

  localparam int DEFAULT_ADDR_W       = 19;
  localparam int DEFAULT_DATA_W       = 36;
  localparam int DEFAULT_READ_LATENCY = 2;

  typedef logic [1:0] req_id_t;

  localparam req_id_t ID_NONE = 2'd0;
  localparam req_id_t ID_VGA  = 2'd1;
  localparam req_id_t ID_CAM  = 2'd2;
  localparam req_id_t ID_XF   = 2'd3;

  // Encoding of the one-bit round-robin pointer between camera and transform.
  localparam logic LAST_CAM = 1'b0;
  localparam logic LAST_XF  = 1'b1;

endpackage

// File: rtl/frame_mem_arbiter_read_tag_pipe.sv
// Fixed-depth shift register of requester IDs that tracks outstanding reads
// until their data comes back from memory.
module read_tag_pipe
  import frame_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1 + DEFAULT_READ_LATENCY
) (
  input  logic    clk,
  input  logic    reset,
  input  req_id_t tag_in,
  output req_id_t tag_out
);

  req_id_t stages [DEPTH];

  // Shift tags one stage per cycle; reset drops every outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= ID_NONE;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/frame_mem_arbiter.sv
// Single-port frame memory arbiter: VGA has fixed priority, camera and
// transform share the remaining slots round-robin under main_fsm enables.
module frame_mem_arbiter
  import frame_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_enable,
  input  logic              xf_enable,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  input  logic              cam_req,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_gnt,
  input  logic              xf_req,
  input  logic              xf_we,
  input  logic [ADDR_W-1:0] xf_addr,
  input  logic [DATA_W-1:0] xf_wdata,
  output logic              xf_gnt,
  output logic              xf_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic    cam_elig;
  logic    xf_elig;
  logic    last_rr;
  req_id_t tag_in;
  req_id_t tag_out;

  assign cam_elig = cam_req & cam_enable;
  assign xf_elig  = xf_req & xf_enable;

  // Grant selection: VGA first, then whichever of cam/xf did not win last.
  always_comb begin
    vga_gnt = 1'b0;
    cam_gnt = 1'b0;
    xf_gnt  = 1'b0;
    if (reset) begin
      vga_gnt = 1'b0;
    end else if (vga_req) begin
      vga_gnt = 1'b1;
    end else if (cam_elig && xf_elig) begin
      if (last_rr == LAST_XF) begin
        cam_gnt = 1'b1;
      end else begin
        xf_gnt = 1'b1;
      end
    end else if (cam_elig) begin
      cam_gnt = 1'b1;
    end else if (xf_elig) begin
      xf_gnt = 1'b1;
    end else begin
      vga_gnt = 1'b0;
    end
  end

  // Only reads need a returning tag; writes and idle cycles push ID_NONE.
  always_comb begin
    tag_in = ID_NONE;
    if (vga_gnt) begin
      tag_in = ID_VGA;
    end else if (xf_gnt && !xf_we) begin
      tag_in = ID_XF;
    end else begin
      tag_in = ID_NONE;
    end
  end

  // Round-robin pointer, moved only by camera or transform grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_rr <= LAST_XF;
    end else if (cam_gnt) begin
      last_rr <= LAST_CAM;
    end else if (xf_gnt) begin
      last_rr <= LAST_XF;
    end else begin
      last_rr <= last_rr;
    end
  end

  // Memory command register: address and data hold when idle, write enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (vga_gnt) begin
      mem_addr <= vga_addr;
      mem_we   <= 1'b0;
    end else if (cam_gnt) begin
      mem_addr  <= cam_addr;
      mem_we    <= 1'b1;
      mem_wdata <= cam_wdata;
    end else if (xf_gnt) begin
      mem_addr  <= xf_addr;
      mem_we    <= xf_we;
      mem_wdata <= xf_wdata;
    end else begin
      mem_we <= 1'b0;
    end
  end

  read_tag_pipe #(
    .DEPTH (1 + READ_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign vga_rvalid = (tag_out == ID_VGA);
  assign xf_rvalid  = (tag_out == ID_XF);
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed self-checking bench for frame_mem_arbiter with a two-cycle
// read-latency memory model whose data is a fixed function of the address.
module tb_frame_mem_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;

  logic              clk;
  logic              reset;
  logic              cam_enable;
  logic              xf_enable;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic              cam_req;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_wdata;
  logic              cam_gnt;
  logic              xf_req;
  logic              xf_we;
  logic [ADDR_W-1:0] xf_addr;
  logic [DATA_W-1:0] xf_wdata;
  logic              xf_gnt;
  logic              xf_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [ADDR_W-1:0] addr_d1;
  logic [ADDR_W-1:0] addr_d2;

  int checks = 0;
  int errors = 0;

  frame_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cam_enable (cam_enable),
    .xf_enable  (xf_enable),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .cam_req    (cam_req),
    .cam_addr   (cam_addr),
    .cam_wdata  (cam_wdata),
    .cam_gnt    (cam_gnt),
    .xf_req     (xf_req),
    .xf_we      (xf_we),
    .xf_addr    (xf_addr),
    .xf_wdata   (xf_wdata),
    .xf_gnt     (xf_gnt),
    .xf_rvalid  (xf_rvalid),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_pat(input logic [ADDR_W-1:0] a);
    return {17'h0, a} ^ 36'hA5A50F0F3;
  endfunction

  // Memory model: data for the address presented appears two cycles later.
  always @(posedge clk) begin
    addr_d1 <= mem_addr;
    addr_d2 <= addr_d1;
  end
  assign mem_rdata = mem_pat(addr_d2);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cam_enable = 1'b0; xf_enable = 1'b0;
    vga_req = 1'b1; vga_addr = 19'h0;
    cam_req = 1'b0; cam_addr = 19'h0; cam_wdata = 36'h0;
    xf_req = 1'b0; xf_we = 1'b0; xf_addr = 19'h0; xf_wdata = 36'h0;
    step(); step();
    #1;
    check("rst_vga_gnt", vga_gnt, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 19'h0);
    check("rst_mem_wdata", mem_wdata, 36'h0);
    check("rst_rvalid", {vga_rvalid, xf_rvalid}, 2'b00);
    vga_req = 1'b0;
    reset = 1'b0;
    step();

    // Single VGA read and its return latency.
    vga_req = 1'b1; vga_addr = 19'h100;
    #1;
    check("vga_gnt", vga_gnt, 1'b1);
    check("vga_only_gnt", {cam_gnt, xf_gnt}, 2'b00);
    step();
    vga_req = 1'b0;
    #1;
    check("vga_mem_addr", mem_addr, 19'h100);
    check("vga_mem_we", mem_we, 1'b0);
    check("vga_rvalid_c1", vga_rvalid, 1'b0);
    step();
    check("vga_rvalid_c2", vga_rvalid, 1'b0);
    step();
    check("vga_rvalid_c3", vga_rvalid, 1'b1);
    check("vga_xf_rvalid_c3", xf_rvalid, 1'b0);
    check("vga_rdata", rdata, mem_pat(19'h100));
    step();
    check("vga_rvalid_c4", vga_rvalid, 1'b0);

    // Camera and transform writes alternate, camera first after reset.
    cam_enable = 1'b1; xf_enable = 1'b1;
    cam_req = 1'b1; cam_addr = 19'h200; cam_wdata = 36'h111111111;
    xf_req = 1'b1; xf_we = 1'b1; xf_addr = 19'h300; xf_wdata = 36'h222222222;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_cam_gnt", cam_gnt, (i % 2 == 0) ? 1'b1 : 1'b0);
      check("rr_xf_gnt", xf_gnt, (i % 2 == 1) ? 1'b1 : 1'b0);
      step();
      check("rr_mem_we", mem_we, 1'b1);
      check("rr_mem_addr", mem_addr, (i % 2 == 0) ? 19'h200 : 19'h300);
      check("rr_mem_wdata", mem_wdata, (i % 2 == 0) ? 36'h111111111 : 36'h222222222);
    end
    cam_req = 1'b0; xf_req = 1'b0;
    step();
    check("idle_mem_we", mem_we, 1'b0);
    check("idle_mem_addr_hold", mem_addr, 19'h300);
    check("idle_mem_wdata_hold", mem_wdata, 36'h222222222);

    // VGA blocks cam/xf; pointer untouched by three VGA grants.
    vga_req = 1'b1; vga_addr = 19'h40;
    cam_req = 1'b1; xf_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("vgablk_vga_gnt", vga_gnt, 1'b1);
      check("vgablk_cam_gnt", cam_gnt, 1'b0);
      check("vgablk_xf_gnt", xf_gnt, 1'b0);
      step();
    end
    vga_req = 1'b0;
    #1;
    check("vgablk_cam_after", cam_gnt, 1'b1);
    check("vgablk_xf_after", xf_gnt, 1'b0);
    step();
    cam_req = 1'b0; xf_req = 1'b0;
    step(); step(); step(); step();

    // Disabled camera never granted until enable rises.
    cam_enable = 1'b0; cam_req = 1'b1; cam_addr = 19'h7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dis_cam_gnt", cam_gnt, 1'b0);
      step();
      check("dis_mem_we", mem_we, 1'b0);
    end
    cam_enable = 1'b1;
    #1;
    check("en_cam_gnt", cam_gnt, 1'b1);
    step();
    cam_req = 1'b0;
    check("en_mem_we", mem_we, 1'b1);
    check("en_mem_addr", mem_addr, 19'h7);
    step(); step(); step();

    // Interleaved reads VGA, XF, VGA return in order.
    vga_req = 1'b1; vga_addr = 19'h10;
    #1;
    check("il_gnt0", vga_gnt, 1'b1);
    step();
    vga_req = 1'b0; xf_req = 1'b1; xf_we = 1'b0; xf_addr = 19'h20;
    #1;
    check("il_gnt1", xf_gnt, 1'b1);
    step();
    xf_req = 1'b0; vga_req = 1'b1; vga_addr = 19'h30;
    #1;
    check("il_gnt2", vga_gnt, 1'b1);
    step();
    vga_req = 1'b0;
    #1;
    check("il_rv0", {vga_rvalid, xf_rvalid}, 2'b10);
    check("il_rd0", rdata, mem_pat(19'h10));
    step();
    check("il_rv1", {vga_rvalid, xf_rvalid}, 2'b01);
    check("il_rd1", rdata, mem_pat(19'h20));
    step();
    check("il_rv2", {vga_rvalid, xf_rvalid}, 2'b10);
    check("il_rd2", rdata, mem_pat(19'h30));
    step();
    check("il_rv3", {vga_rvalid, xf_rvalid}, 2'b00);

    // Reset one cycle after an xf read grant drops the read.
    xf_req = 1'b1; xf_we = 1'b0; xf_addr = 19'h55;
    #1;
    check("rr_xf_read_gnt", xf_gnt, 1'b1);
    step();
    reset = 1'b1; xf_req = 1'b1; cam_req = 1'b1; vga_req = 1'b1; xf_we = 1'b1;
    #1;
    check("mid_rst_gnt", {vga_gnt, cam_gnt, xf_gnt}, 3'b000);
    check("mid_rst_xf_rvalid_c1", xf_rvalid, 1'b0);
    step();
    reset = 1'b0; vga_req = 1'b0;
    #1;
    check("post_rst_mem_we", mem_we, 1'b0);
    check("post_rst_mem_addr", mem_addr, 19'h0);
    check("post_rst_xf_rvalid_c2", xf_rvalid, 1'b0);
    check("post_rst_tie_cam", cam_gnt, 1'b1);
    check("post_rst_tie_xf", xf_gnt, 1'b0);
    step();
    cam_req = 1'b0; xf_req = 1'b0;
    check("post_rst_xf_rvalid_c3", xf_rvalid, 1'b0);
    check("post_rst_cam_write", mem_we, 1'b1);
    step();
    check("post_rst_xf_rvalid_c4", xf_rvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Shares the single-port frame memory between three requesters: VGA display read, camera capture write, and perspective-transform engine read/write.
- Sits between main_fsm and the memory. main_fsm drives the per-requester enables from its current state.
- VGA has fixed top priority. Camera and transform alternate round-robin.
- Read data is returned with a per-requester valid pulse after a fixed pipeline latency.

Parameters:
- ADDR_W, 19, memory word address width
- DATA_W, 36, memory data width
- READ_LATENCY, 2, cycles from mem_addr presented to mem_rdata valid

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cam_enable  in  1  from main_fsm; camera may be granted only when high
- xf_enable  in  1  from main_fsm; transform may be granted only when high
- vga_req  in  1  VGA read request
- vga_addr  in  ADDR_W  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rvalid  out  1  rdata belongs to VGA this cycle
- cam_req  in  1  camera write request
- cam_addr  in  ADDR_W  camera write address
- cam_wdata  in  DATA_W  camera write data
- cam_gnt  out  1  camera request accepted this cycle
- xf_req  in  1  transform request
- xf_we  in  1  transform request type: 1 write, 0 read
- xf_addr  in  ADDR_W  transform address
- xf_wdata  in  DATA_W  transform write data
- xf_gnt  out  1  transform request accepted this cycle
- xf_rvalid  out  1  rdata belongs to transform this cycle
- rdata  out  DATA_W  read data, passthrough of mem_rdata
- mem_addr  out  ADDR_W  memory address, registered
- mem_we  out  1  memory write enable, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Grants are combinational from the current reqs, enables and round-robin pointer.
  - At most one grant per cycle.
  - A request transfers when req and gnt are both high on a clock edge.
  - Requesters hold req, address and data stable until granted.
- Priority:
  - vga_req wins unconditionally.
  - Otherwise eligible requesters are cam (cam_req && cam_enable) and xf (xf_req && xf_enable).
  - If only one is eligible, it wins.
  - If both are eligible, the one not granted last wins.
- Pointer:
  - 1 bit, last_rr, records the last cam/xf winner.
  - Updated only on a cam or xf grant; VGA grants leave it unchanged.
- A disabled requester never gets a grant, whatever its req. An enable dropping mid-request simply withholds the grant.
- Memory side:
  - The cycle after a grant, mem_addr, mem_we and mem_wdata carry the granted request.
  - With no grant, mem_we=0 and mem_addr/mem_wdata hold their previous values.
- Read return:
  - A tag pipeline of depth 1+READ_LATENCY carries the requester ID of each granted read (NONE for writes and idle cycles).
  - The tag emerging at the end raises exactly one of vga_rvalid/xf_rvalid for one cycle.
  - Grant-to-rvalid latency is 1+READ_LATENCY cycles (3 at default).
  - The pipeline is fully pipelined: back-to-back reads give back-to-back valids, in order.
- rdata = mem_rdata combinationally. It is meaningful only when an rvalid is high.
- Reset:
  - All gnt outputs are 0 while reset is high.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - All tags are set to NONE, so vga_rvalid=0 and xf_rvalid=0.
  - last_rr=xf, so cam wins the first tie.
- Reset mid-operation: outstanding reads are dropped and no rvalid is emitted for them.
- Simultaneous events:
  - VGA and cam/xf requesting together: the VGA grant never blocks the rvalid of an earlier cam/xf read.
  - A write grant in the same cycle as an rvalid is legal.

Decomposition:
- Shared package holds:
  - requester ID constants: ID_NONE=2'd0, ID_VGA=2'd1, ID_CAM=2'd2, ID_XF=2'd3
  - default ADDR_W, DATA_W and READ_LATENCY
- One sub-module: read_tag_pipe (parameterised-depth shift register of 2-bit IDs with synchronous reset to ID_NONE).
- Grant logic and memory registers stay in the top module.

Test Plan:
- Reset, then vga_req=1, vga_addr=0x100 -> vga_gnt=1 in the same cycle; next cycle mem_addr=0x100, mem_we=0; vga_rvalid=1 exactly 3 cycles after the grant edge, with rdata=mem_rdata.
- cam_req and xf_req held high, both enabled, xf_we=1, no VGA, for 6 cycles -> grants alternate cam,xf,cam,xf,cam,xf; mem_we=1 each cycle after a grant.
- vga_req held high with cam_req high -> cam_gnt stays 0 until vga_req drops, then cam_gnt=1 next cycle; the pointer is unchanged by the VGA grants.
- cam_req=1 with cam_enable=0 -> cam_gnt stays 0 and mem_we stays 0; raise cam_enable -> cam_gnt=1 that cycle.
- Interleaved reads VGA@0x10, XF@0x20, VGA@0x30 on consecutive cycles -> rvalids vga,xf,vga on 3 consecutive cycles starting 3 cycles after the first grant.
- xf read granted, reset asserted 1 cycle later for 1 cycle -> xf_rvalid never asserts, mem_we=0, all gnt=0 during reset; next tie goes to cam.
